// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage access controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MM_WAIT,
    ST_FB_ARB,
    ST_RD_CAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_MM,
    K_FB,
    K_CS
  } kind_t;

  localparam logic [1:0] LANE_BOT = 2'b01;
  localparam logic [1:0] LANE_TOP = 2'b10;

  localparam int MM_TIMEOUT_DEF  = 15;
  localparam int FB_MAX_WAIT_DEF = 4;

  // Fixed priority mm > fb > cs.
  function automatic kind_t decode_kind(input logic mm, input logic fb, input logic cs);
    if (mm)      return K_MM;
    else if (fb) return K_FB;
    else if (cs) return K_CS;
    else         return K_NONE;
  endfunction

  function automatic logic multi_req(input logic mm, input logic fb, input logic cs);
    return (mm & fb) | (mm & cs) | (fb & cs);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Main-memory req/ack bus between the MEM-stage controller and the memory.
interface mem_access_ctrl_if #(parameter int ADDR_W = 16) ();
  logic              mm_req;
  logic [1:0]        mm_we;
  logic [ADDR_W-1:0] mm_addr;
  logic [15:0]       mm_wdata;
  logic              mm_ack;
  logic [15:0]       mm_rdata;

  modport master (output mm_req, mm_we, mm_addr, mm_wdata, input mm_ack, mm_rdata);
  modport slave  (input mm_req, mm_we, mm_addr, mm_wdata, output mm_ack, mm_rdata);
endinterface

// File: rtl/mem_access_ctrl_fb_port_arbiter.sv
// Frame buffer port arbitration: video wins by default, but the CPU is forced
// onto the port after MAX_WAIT consecutive video-won cycles.
module fb_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = FB_MAX_WAIT_DEF
) (
  input  logic clock,
  input  logic nreset,
  input  logic active,
  input  logic vid_req,
  output logic vid_grant,
  output logic cpu_issue
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          video_wins;

  assign video_wins = active && vid_req && (wait_cnt < CW'(MAX_WAIT));
  assign vid_grant  = active ? video_wins : vid_req;
  assign cpu_issue  = active && !video_wins;

  always_ff @(posedge clock) begin
    if (!nreset)         wait_cnt <= '0;
    else if (video_wins) wait_cnt <= wait_cnt + 1'b1;
    else                 wait_cnt <= '0;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: routes the EX/MEM access to main memory, frame buffer
// or call stack, and raises a registered stall while the access is outstanding.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MM_TIMEOUT  = MM_TIMEOUT_DEF,
  parameter int FB_MAX_WAIT = FB_MAX_WAIT_DEF
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              req_mm_in,
  input  logic              req_fb_in,
  input  logic              req_cs_in,
  input  logic [1:0]        wren_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [15:0]       wdata_in,
  output logic              stall,
  output logic [15:0]       rdata,
  output logic              rdata_valid,
  output logic              err,
  mem_access_ctrl_if.master mm,
  input  logic              vid_req,
  output logic              vid_grant,
  output logic              fb_en,
  output logic [1:0]        fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_wdata,
  input  logic [15:0]       fb_rdata,
  output logic              cs_en,
  output logic [1:0]        cs_we,
  output logic [ADDR_W-1:0] cs_addr,
  output logic [15:0]       cs_wdata,
  input  logic [15:0]       cs_rdata
);

  localparam int CW = $clog2(MM_TIMEOUT + 1);

  state_t            state, state_nx;
  kind_t             kind_q, kind_in;
  logic [1:0]        wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [CW-1:0]     mm_cnt;
  logic              stall_nx, timeout, is_read, cs_rd_pend, cpu_issue;

  assign kind_in    = decode_kind(req_mm_in, req_fb_in, req_cs_in);
  assign is_read    = (wren_q == 2'b00);
  // A CS read spends its first MEM cycle in IDLE with the stall already up.
  assign cs_rd_pend = (state == ST_IDLE) && (kind_q == K_CS) && is_read;

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (cs_rd_pend) begin
          state_nx = ST_RD_CAP;
        end else begin
          case (kind_in)
            K_MM:    state_nx = ST_MM_WAIT;
            K_FB:    state_nx = ST_FB_ARB;
            default: state_nx = ST_IDLE;
          endcase
        end
      end
      ST_MM_WAIT: begin
        if (mm.mm_ack) begin
          state_nx = ST_DONE;
        end else if (mm_cnt == CW'(MM_TIMEOUT - 1)) begin
          state_nx = ST_DONE;
          timeout  = 1'b1;
        end
      end
      ST_FB_ARB: if (cpu_issue) state_nx = is_read ? ST_RD_CAP : ST_DONE;
      ST_RD_CAP: state_nx = ST_DONE;
      default:   state_nx = ST_IDLE;
    endcase
    stall_nx = (state_nx inside {ST_MM_WAIT, ST_FB_ARB, ST_RD_CAP}) ||
               (!stall && (kind_in == K_CS) && (wren_in == 2'b00));
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      stall   <= 1'b0;
      kind_q  <= K_NONE;
      wren_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mm_cnt  <= '0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      stall <= stall_nx;
      if (!stall) begin
        kind_q  <= kind_in;
        wren_q  <= wren_in;
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
      mm_cnt <= (state == ST_MM_WAIT && state_nx == ST_MM_WAIT) ? mm_cnt + 1'b1 : '0;
      err    <= (!stall && multi_req(req_mm_in, req_fb_in, req_cs_in)) || timeout;
      if (state == ST_RD_CAP)
        rdata <= (kind_q == K_CS) ? cs_rdata : fb_rdata;
      else if (state == ST_MM_WAIT && mm.mm_ack && is_read)
        rdata <= mm.mm_rdata;
      else if (timeout)
        rdata <= '0;
    end
  end

  fb_port_arbiter #(.MAX_WAIT(FB_MAX_WAIT)) u_fb_arb (
    .clock     (clock),
    .nreset    (nreset),
    .active    (state == ST_FB_ARB),
    .vid_req   (vid_req),
    .vid_grant (vid_grant),
    .cpu_issue (cpu_issue)
  );

  assign rdata_valid = (state == ST_DONE) && is_read;

  assign mm.mm_req   = (state == ST_MM_WAIT);
  assign mm.mm_we    = mm.mm_req ? wren_q : 2'b00;
  assign mm.mm_addr  = addr_q;
  assign mm.mm_wdata = wdata_q;

  assign fb_en    = (state == ST_FB_ARB) && cpu_issue;
  assign fb_we    = fb_en ? wren_q : 2'b00;
  assign fb_addr  = addr_q;
  assign fb_wdata = wdata_q;

  assign cs_en    = (state == ST_IDLE) && (kind_q == K_CS);
  assign cs_we    = cs_en ? wren_q : 2'b00;
  assign cs_addr  = addr_q;
  assign cs_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with small CS/FB memory models.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        nreset;
  logic        req_mm_in, req_fb_in, req_cs_in;
  logic [1:0]  wren_in;
  logic [15:0] addr_in, wdata_in;
  logic        stall, rdata_valid, err;
  logic [15:0] rdata;
  logic        vid_req, vid_grant, fb_en, cs_en;
  logic [1:0]  fb_we, cs_we;
  logic [15:0] fb_addr, fb_wdata, cs_addr, cs_wdata;
  logic [15:0] fb_rdata = 16'h0000;
  logic [15:0] cs_rdata = 16'h0000;
  logic [15:0] cs_mem [256];

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl_if #(.ADDR_W(16)) mm_if ();

  mem_access_ctrl #(.ADDR_W(16), .MM_TIMEOUT(15), .FB_MAX_WAIT(4)) dut (
    .clock(clock), .nreset(nreset),
    .req_mm_in(req_mm_in), .req_fb_in(req_fb_in), .req_cs_in(req_cs_in),
    .wren_in(wren_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .mm(mm_if.master),
    .vid_req(vid_req), .vid_grant(vid_grant),
    .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
    .cs_en(cs_en), .cs_we(cs_we), .cs_addr(cs_addr), .cs_wdata(cs_wdata), .cs_rdata(cs_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous call-stack RAM with byte lanes.
  always @(posedge clock) begin
    if (cs_en) begin
      if (cs_we[0]) cs_mem[cs_addr[7:0]][7:0]  <= cs_wdata[7:0];
      if (cs_we[1]) cs_mem[cs_addr[7:0]][15:8] <= cs_wdata[15:8];
      cs_rdata <= cs_mem[cs_addr[7:0]];
    end
  end

  // Frame buffer returns an address-tagged word one cycle after a CPU read.
  always @(posedge clock) begin
    if (fb_en && fb_we == 2'b00) fb_rdata <= {8'hCA, fb_addr[7:0]};
  end

  typedef struct {
    logic [2:0]  req;   // {mm, fb, cs}
    logic [1:0]  wren;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] mrd;
    logic        vid;
    logic [15:0] ma;    // expected mm_addr while mm_req
    logic        s, v, e, mq, ce;
    logic [1:0]  cwe;
    logic        fe, vg;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic [1:0] wren, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic ack, input logic [15:0] mrd,
                       input logic vid);
    req_mm_in      = req[2];
    req_fb_in      = req[1];
    req_cs_in      = req[0];
    wren_in        = wren;
    addr_in        = addr;
    wdata_in       = wdata;
    mm_if.mm_ack   = ack;
    mm_if.mm_rdata = mrd;
    vid_req        = vid;
  endtask

  initial begin
    logic [1:0] lanes_all;
    lanes_all = LANE_BOT | LANE_TOP;
    nreset = 1'b0;
    drive(3'b000, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_stall", {15'b0, stall}, 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_valid", {15'b0, rdata_valid}, 16'd0);
    chk("rst_err", {15'b0, err}, 16'd0);
    chk("rst_mm_req", {15'b0, mm_if.mm_req}, 16'd0);
    chk("rst_cs_en", {15'b0, cs_en}, 16'd0);
    chk("rst_fb_en", {15'b0, fb_en}, 16'd0);
    chk("rst_vid_grant", {15'b0, vid_grant}, 16'd1);
    nreset  = 1'b1;
    vid_req = 1'b0;

    //                req     wren       addr      wdata     ack  mrd      vid   ma       s  v  e  mq ce cwe        fe vg rd
    vecs.push_back(vec_t'{3'b001, lanes_all, 16'h0010, 16'hBEEF, 1'b0, 16'h0, 1'b0, 16'h0,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,     1'b0,1'b0, 16'h0000});
    vecs.push_back(vec_t'{3'b001, 2'b00,     16'h0010, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b0,1'b0,1'b0,1'b0,1'b1, lanes_all, 1'b0,1'b0, 16'h0000});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b1,1'b0,1'b0,1'b0,1'b1, 2'b00,     1'b0,1'b0, 16'h0000});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,     1'b0,1'b0, 16'h0000});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,     1'b0,1'b0, 16'hBEEF});
    // MM read, ack in third wait cycle
    vecs.push_back(vec_t'{3'b100, 2'b00,     16'h0200, 16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'hBEEF});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0200, 1'b1,1'b0,1'b0,1'b1,1'b0, 2'b00, 1'b0,1'b0, 16'hBEEF});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0200, 1'b1,1'b0,1'b0,1'b1,1'b0, 2'b00, 1'b0,1'b0, 16'hBEEF});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b1, 16'h1234, 1'b0, 16'h0200, 1'b1,1'b0,1'b0,1'b1,1'b0, 2'b00, 1'b0,1'b0, 16'hBEEF});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'h1234});
    // FB read with video hogging the port
    vecs.push_back(vec_t'{3'b010, 2'b00,     16'h0030, 16'h0,    1'b0, 16'h0, 1'b1, 16'h0,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b1, 16'h1234});
    for (int i = 0; i < 4; i++)
      vecs.push_back(vec_t'{3'b000, 2'b00,   16'h0,    16'h0,    1'b0, 16'h0, 1'b1, 16'h0,  1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b1, 16'h1234});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b1, 16'h0,  1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b0, 16'h1234});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b1, 16'h0,  1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b1, 16'h1234});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b1, 16'h0,  1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b1, 16'hCA30});
    // MM + CS together: MM wins, err pulses once
    vecs.push_back(vec_t'{3'b101, lanes_all, 16'h0040, 16'h5555, 1'b0, 16'h0, 1'b0, 16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'hCA30});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b1, 16'h0, 1'b0, 16'h0040, 1'b1,1'b0,1'b1,1'b1,1'b0, 2'b00, 1'b0,1'b0, 16'hCA30});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'hCA30});
    // FB write with the port free
    vecs.push_back(vec_t'{3'b010, LANE_BOT,  16'h0031, 16'h00AA, 1'b0, 16'h0, 1'b0, 16'h0,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'hCA30});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b0, 16'hCA30});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'hCA30});
    vecs.push_back(vec_t'{3'b000, 2'b00,     16'h0,    16'h0,    1'b0, 16'h0, 1'b0, 16'h0,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 16'hCA30});

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].req, vecs[i].wren, vecs[i].addr, vecs[i].wdata,
            vecs[i].ack, vecs[i].mrd, vecs[i].vid);
      #1;
      chk($sformatf("v%0d_stall", i),  {15'b0, stall},        {15'b0, vecs[i].s});
      chk($sformatf("v%0d_valid", i),  {15'b0, rdata_valid},  {15'b0, vecs[i].v});
      chk($sformatf("v%0d_err", i),    {15'b0, err},          {15'b0, vecs[i].e});
      chk($sformatf("v%0d_mm_req", i), {15'b0, mm_if.mm_req}, {15'b0, vecs[i].mq});
      chk($sformatf("v%0d_cs_en", i),  {15'b0, cs_en},        {15'b0, vecs[i].ce});
      chk($sformatf("v%0d_cs_we", i),  {14'b0, cs_we},        {14'b0, vecs[i].cwe});
      chk($sformatf("v%0d_fb_en", i),  {15'b0, fb_en},        {15'b0, vecs[i].fe});
      chk($sformatf("v%0d_vgrant", i), {15'b0, vid_grant},    {15'b0, vecs[i].vg});
      chk($sformatf("v%0d_rdata", i),  rdata,                 vecs[i].rd);
      if (vecs[i].mq) chk($sformatf("v%0d_mm_addr", i), mm_if.mm_addr, vecs[i].ma);
    end

    // MM write with ack withheld: 15 wait cycles, then abort
    @(negedge clock);
    drive(3'b100, lanes_all, 16'h0080, 16'h7777, 1'b0, 16'h0, 1'b0);
    #1 chk("tmo_issue_stall", {15'b0, stall}, 16'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      drive(3'b000, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      #1;
      chk($sformatf("tmo_w%0d_mm_req", i), {15'b0, mm_if.mm_req}, 16'd1);
      chk($sformatf("tmo_w%0d_stall", i),  {15'b0, stall}, 16'd1);
    end
    @(negedge clock);
    #1;
    chk("tmo_mm_req", {15'b0, mm_if.mm_req}, 16'd0);
    chk("tmo_err", {15'b0, err}, 16'd1);
    chk("tmo_rdata", rdata, 16'h0000);
    chk("tmo_stall", {15'b0, stall}, 16'd0);
    chk("tmo_valid", {15'b0, rdata_valid}, 16'd0);
    @(negedge clock);
    #1 chk("tmo_err_clear", {15'b0, err}, 16'd0);

    // Reset in the middle of an MM read, then a CS read
    @(negedge clock);
    drive(3'b100, 2'b00, 16'h0300, 16'h0, 1'b0, 16'h0, 1'b0);
    @(negedge clock);
    drive(3'b000, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    #1 chk("rmid_mm_req", {15'b0, mm_if.mm_req}, 16'd1);
    @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    drive(3'b001, 2'b00, 16'h0010, 16'h0, 1'b0, 16'h0, 1'b0);
    #1;
    chk("rmid_after_mm_req", {15'b0, mm_if.mm_req}, 16'd0);
    chk("rmid_after_stall", {15'b0, stall}, 16'd0);
    chk("rmid_after_valid", {15'b0, rdata_valid}, 16'd0);
    @(negedge clock);
    drive(3'b000, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    #1;
    chk("rcs_c1_stall", {15'b0, stall}, 16'd1);
    chk("rcs_c1_cs_en", {15'b0, cs_en}, 16'd1);
    @(negedge clock);
    #1 chk("rcs_c2_stall", {15'b0, stall}, 16'd1);
    @(negedge clock);
    #1;
    chk("rcs_c3_stall", {15'b0, stall}, 16'd0);
    chk("rcs_c3_valid", {15'b0, rdata_valid}, 16'd1);
    chk("rcs_c3_rdata", rdata, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

endmodule
